// File: rtl/y86_pkg.sv
// Shared Y86 sequencer definitions: instruction codes, status codes, FSM states.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package y86_pkg;

  // Instruction codes presented by fetch in the icode field.
  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_t;

  // Architectural status reported on the stat output.
  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  // Sequencer states; FETCH..PCUPD are the running states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_PCUPD     = 3'd6,
    ST_HALTED    = 3'd7
  } state_t;

  // Status for a faulting fetch: address error outranks illegal
  // function, which outranks a plain halt.
  function automatic stat_t fetch_stat(input logic mem_error, input logic func_error);
    if (mem_error)  return STAT_ADR;
    if (func_error) return STAT_INS;
    return STAT_HLT;
  endfunction

endpackage

// File: rtl/seq_pc_sel.sv
// Next-PC selection for the sequential Y86 controller.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: icode/Cnd/valC/valP/valM (latched instruction state) -> next_pc.
module seq_pc_sel
  import y86_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [3:0]      icode,
  input  logic            Cnd,
  input  logic [PC_W-1:0] valC,
  input  logic [PC_W-1:0] valP,
  input  logic [PC_W-1:0] valM,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    next_pc = valP;
    case (icode)
      ICALL:   next_pc = valC;
      IJXX:    if (Cnd) next_pc = valC;
      IRET:    next_pc = valM;
      default: next_pc = valP;
    endcase
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle Y86 sequencer: steps FETCH..WRITEBACK, PCUPD per instruction, halts on faults.
// Latency: 6 cycles per instruction plus one per extra MEMORY wait cycle.
// Backpressure: MEMORY stalls until mem_done; MEM_TMO+1 stalled cycles becomes an ADR fault.
// Ports: clk/rst_n (sync, active-low); start/boot_pc launch; icode,valC,valP,mem_error,
//        func_error,halt from fetch; Cnd from execute; valM,mem_done,dmem_error from memory;
//        PC, one-hot stage enables, stat, running, cycle_cnt, instr_cnt out.
module seq_ctrl
  import y86_pkg::*;
#(
  parameter int PC_W    = 64,
  parameter int CNT_W   = 32,
  parameter int MEM_TMO = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  boot_pc,
  input  logic [3:0]       icode,
  input  logic [PC_W-1:0]  valC,
  input  logic [PC_W-1:0]  valP,
  input  logic             mem_error,
  input  logic             func_error,
  input  logic             halt,
  input  logic             Cnd,
  input  logic [PC_W-1:0]  valM,
  input  logic             mem_done,
  input  logic             dmem_error,
  output logic [PC_W-1:0]  PC,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic [2:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  // Wide enough to hold MEM_TMO itself, and at least one bit.
  localparam int TMO_W = $clog2(MEM_TMO + 2);

  state_t            state_q, state_d;
  stat_t             stat_q, stat_d;
  logic [TMO_W-1:0]  tmo_q;
  logic              tmo_hit;

  logic [3:0]        icode_q;
  logic [PC_W-1:0]   valc_q;
  logic [PC_W-1:0]   valp_q;
  logic [PC_W-1:0]   valm_q;
  logic              cnd_q;
  logic [PC_W-1:0]   next_pc;

  seq_pc_sel #(.PC_W(PC_W)) u_pc_sel (
    .icode   (icode_q),
    .Cnd     (cnd_q),
    .valC    (valc_q),
    .valP    (valp_q),
    .valM    (valm_q),
    .next_pc (next_pc)
  );

  // tmo_q holds the index of the current MEMORY cycle, so a hit marks the
  // (MEM_TMO+1)th consecutive cycle without mem_done.
  assign tmo_hit = (tmo_q == TMO_W'(MEM_TMO));

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_en    = 1'b0;
    wb_en     = 1'b0;
    running   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          stat_d  = STAT_AOK;
        end
      end
      ST_FETCH: begin
        fetch_en = 1'b1;
        running  = 1'b1;
        if (mem_error || func_error || halt) begin
          state_d = ST_HALTED;
          stat_d  = fetch_stat(mem_error, func_error);
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        decode_en = 1'b1;
        running   = 1'b1;
        state_d   = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        exec_en = 1'b1;
        running = 1'b1;
        state_d = ST_MEMORY;
      end
      ST_MEMORY: begin
        mem_en  = 1'b1;
        running = 1'b1;
        // A data-memory error wins over a completion in the same cycle.
        if (dmem_error) begin
          state_d = ST_HALTED;
          stat_d  = STAT_ADR;
        end else if (mem_done) begin
          state_d = ST_WRITEBACK;
        end else if (tmo_hit) begin
          state_d = ST_HALTED;
          stat_d  = STAT_ADR;
        end
      end
      ST_WRITEBACK: begin
        wb_en   = 1'b1;
        running = 1'b1;
        state_d = ST_PCUPD;
      end
      ST_PCUPD: begin
        running = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      stat_q    <= STAT_AOK;
      PC        <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      tmo_q     <= '0;
      icode_q   <= '0;
      valc_q    <= '0;
      valp_q    <= '0;
      valm_q    <= '0;
      cnd_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;

      if (running) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end

      if (state_q == ST_MEMORY && state_d == ST_MEMORY) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end else begin
        tmo_q <= '0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) PC <= boot_pc;
        end
        ST_FETCH: begin
          icode_q <= icode;
          valc_q  <= valC;
          valp_q  <= valP;
        end
        ST_EXECUTE: begin
          cnd_q <= Cnd;
        end
        ST_MEMORY: begin
          if (!dmem_error && mem_done) valm_q <= valM;
        end
        ST_PCUPD: begin
          PC        <= next_pc;
          instr_cnt <= instr_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign stat = stat_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: stimulus pushes expected outcomes, monitor pops on retire/halt.
// Latency: n/a.
// Backpressure: bench models memory wait states and faults.
module tb_seq_ctrl;
  import y86_pkg::*;

  localparam int PC_W    = 64;
  localparam int CNT_W   = 32;
  localparam int MEM_TMO = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [PC_W-1:0]   boot_pc;
  logic [3:0]        icode;
  logic [PC_W-1:0]   valC, valP, valM;
  logic              mem_error, func_error, halt, Cnd, mem_done, dmem_error;
  logic [PC_W-1:0]   PC;
  logic              fetch_en, decode_en, exec_en, mem_en, wb_en, running;
  logic [2:0]        stat;
  logic [CNT_W-1:0]  cycle_cnt, instr_cnt;

  always #5 clk = ~clk;

  seq_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .boot_pc(boot_pc),
    .icode(icode), .valC(valC), .valP(valP), .mem_error(mem_error),
    .func_error(func_error), .halt(halt), .Cnd(Cnd), .valM(valM),
    .mem_done(mem_done), .dmem_error(dmem_error), .PC(PC),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .mem_en(mem_en), .wb_en(wb_en), .stat(stat), .running(running),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  typedef struct {
    bit          is_halt;
    logic [2:0]  stat;
    logic [63:0] pc;
    logic [31:0] icnt;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] m_pc;
  logic [31:0] m_icnt;
  logic [31:0] m_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Architectural next-PC rule.
  function automatic logic [63:0] ref_next_pc(input logic [3:0] ic, input logic cnd,
                                              input logic [63:0] vc, vp, vm);
    if (ic == 4'h8 || (ic == 4'h7 && cnd)) return vc;
    if (ic == 4'h9) return vm;
    return vp;
  endfunction

  task automatic scramble_fetch();
    icode      = 4'($urandom);
    valC       = rand64();
    valP       = rand64();
    mem_error  = 1'b0;
    func_error = 1'b0;
    halt       = 1'b0;
  endtask

  // Monitor: one scoreboard entry per retire (instr_cnt step) or halt (running drop with fault status).
  logic        prev_running = 1'b0;
  logic [31:0] prev_icnt    = '0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1 &&
        (instr_cnt == prev_icnt + 32'd1 || (prev_running && !running && stat != STAT_AOK))) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: DUT output event with no expected entry");
      end else begin
        mon_e = sb.pop_front();
        check("evt_halted", 64'(!running), 64'(mon_e.is_halt));
        check("evt_stat",   64'(stat),      64'(mon_e.stat));
        check("evt_pc",     PC,             mon_e.pc);
        check("evt_icnt",   64'(instr_cnt), 64'(mon_e.icnt));
        check("evt_cycles", 64'(cycle_cnt), 64'(mon_e.cyc));
      end
    end
    prev_running <= running;
    prev_icnt    <= instr_cnt;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"},      PC, 64'h0);
    check({tag, "_enables"}, 64'({fetch_en, decode_en, exec_en, mem_en, wb_en}), 64'h0);
    check({tag, "_stat"},    64'(stat), 64'(STAT_AOK));
    check({tag, "_running"}, 64'(running), 64'h0);
    check({tag, "_cycles"},  64'(cycle_cnt), 64'h0);
    check({tag, "_icnt"},    64'(instr_cnt), 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    mem_done = 1'b0;
    dmem_error = 1'b0;
    scramble_fetch();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("sb_drained", 64'(sb.size()), 64'h0);
    sb.delete();
    m_pc   = '0;
    m_icnt = '0;
    m_cyc  = '0;
  endtask

  task automatic pulse_start(input logic [63:0] bp);
    boot_pc = bp;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    boot_pc = rand64();
    m_pc    = bp;
  endtask

  // wait_c: MEMORY cycle index carrying mem_done; derr_c: index carrying dmem_error (-1 none).
  task automatic run_instr(input logic [3:0] ic, input logic [63:0] vc, vp, vm, input logic cnd,
                           input int wait_c, input int derr_c,
                           input logic merr, input logic ferr, input logic hlt);
    exp_t e;
    int   n;
    int   i;
    logic [63:0] fpc;
    fpc       = m_pc;
    e.pc      = m_pc;
    e.is_halt = 1'b1;
    e.stat    = STAT_ADR;
    if (merr || ferr || hlt) begin
      e.stat = merr ? STAT_ADR : (ferr ? STAT_INS : STAT_HLT);
      m_cyc  = m_cyc + 32'd1;
    end else if (derr_c >= 0 && derr_c <= wait_c && derr_c <= MEM_TMO) begin
      m_cyc = m_cyc + 32'(4 + derr_c);
    end else if (wait_c <= MEM_TMO) begin
      e.is_halt = 1'b0;
      e.stat    = STAT_AOK;
      m_cyc     = m_cyc + 32'(6 + wait_c);
      m_icnt    = m_icnt + 32'd1;
      m_pc      = ref_next_pc(ic, cnd, vc, vp, vm);
      e.pc      = m_pc;
    end else begin
      m_cyc = m_cyc + 32'(4 + MEM_TMO);
    end
    e.icnt = m_icnt;
    e.cyc  = m_cyc;
    sb.push_back(e);

    n = 0;
    while (fetch_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (fetch_en !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL fetch_wait: fetch_en=%b after %0d cycles, expected 1", fetch_en, n);
      return;
    end
    check("fetch_pc", PC, fpc);
    icode = ic; valC = vc; valP = vp;
    mem_error = merr; func_error = ferr; halt = hlt;
    @(negedge clk);
    scramble_fetch();
    if (merr || ferr || hlt) return;
    @(negedge clk);
    Cnd = cnd;
    @(negedge clk);
    Cnd = 1'($urandom);
    i = 0;
    while (mem_en === 1'b1 && i <= MEM_TMO + 2) begin
      mem_done   = (i == wait_c);
      dmem_error = (i == derr_c);
      valM       = (i == wait_c) ? vm : rand64();
      @(negedge clk);
      i++;
    end
    mem_done   = 1'b0;
    dmem_error = 1'b0;
    valM       = rand64();
  endtask

  task automatic run_random_good();
    int w;
    w = ($urandom_range(0, 7) == 0) ? MEM_TMO : int'($urandom_range(0, 3));
    run_instr(4'($urandom_range(1, 11)), rand64(), rand64(), rand64(), 1'($urandom),
              w, -1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; boot_pc = '0;
    Cnd = 1'b0; valM = '0; mem_done = 1'b0; dmem_error = 1'b0;
    scramble_fetch();
    m_pc = '0; m_icnt = '0; m_cyc = '0;

    do_reset();
    check_reset_vals("reset");
    repeat (3) @(negedge clk);
    check("idle_running", 64'(running), 64'h0);
    check("idle_fetch_en", 64'(fetch_en), 64'h0);

    // nop from boot_pc 0, memory completes immediately
    pulse_start(64'h0);
    run_instr(INOP, rand64(), 64'h1, rand64(), 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("nop_pc", PC, 64'h1);
    check("nop_icnt", 64'(instr_cnt), 64'h1);
    check("nop_cycles", 64'(cycle_cnt), 64'h6);

    run_instr(IJXX, 64'h40, rand64(), rand64(), 1'b1, 0, -1, 1'b0, 1'b0, 1'b0);
    run_instr(IJXX, rand64(), 64'h09, rand64(), 1'b0, 1, -1, 1'b0, 1'b0, 1'b0);
    run_instr(IRET, rand64(), rand64(), 64'h100, 1'($urandom), 2, -1, 1'b0, 1'b0, 1'b0);
    run_instr(ICALL, 64'h200, rand64(), rand64(), 1'($urandom), 0, -1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("call_pc", PC, 64'h200);

    for (int k = 0; k < 30; k++) run_random_good();
    run_instr(IHALT, rand64(), rand64(), rand64(), 1'b0, 0, -1, 1'b0, 1'b0, 1'b1);

    // fetch fault: mem_error outranks func_error; start afterwards is ignored
    do_reset();
    pulse_start(64'd1024);
    run_instr(INOP, rand64(), rand64(), rand64(), 1'b0, 0, -1, 1'b1, 1'b1, 1'b0);
    boot_pc = 64'h77;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    repeat (4) @(negedge clk);
    check("halted_pc", PC, 64'd1024);
    check("halted_stat", 64'(stat), 64'(STAT_ADR));
    check("halted_running", 64'(running), 64'h0);
    check("halted_fetch_en", 64'(fetch_en), 64'h0);

    // memory timeout: mem_done never arrives
    do_reset();
    pulse_start(64'h300);
    run_instr(IMRMOVQ, rand64(), rand64(), rand64(), 1'b0, 1000, -1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("tmo_stat", 64'(stat), 64'(STAT_ADR));

    // dmem_error together with mem_done
    do_reset();
    pulse_start(64'h10);
    run_instr(INOP, rand64(), 64'h11, rand64(), 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);
    run_instr(IMRMOVQ, rand64(), rand64(), rand64(), 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("dmem_stat", 64'(stat), 64'(STAT_ADR));
    check("dmem_icnt", 64'(instr_cnt), 64'h1);

    // reset in the second MEMORY cycle aborts the instruction
    do_reset();
    pulse_start(64'h500);
    icode = INOP; valP = 64'h501;
    @(negedge clk);
    scramble_fetch();
    @(negedge clk);
    @(negedge clk);
    mem_done = 1'b0;
    @(negedge clk);
    check("abort_in_mem", 64'(mem_en), 64'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("abort");

    // random episodes, each ending in a random fault
    for (int ep = 0; ep < 4; ep++) begin
      int kind;
      int w;
      do_reset();
      pulse_start(rand64());
      for (int k = 0; k < 10; k++) run_random_good();
      kind = int'($urandom_range(0, 4));
      w    = int'($urandom_range(0, 4));
      case (kind)
        0: run_instr(IHALT, rand64(), rand64(), rand64(), 1'b0, 0, -1, 1'b0, 1'b0, 1'b1);
        1: run_instr(INOP, rand64(), rand64(), rand64(), 1'b0, 0, -1, 1'b0, 1'b1, 1'($urandom));
        2: run_instr(INOP, rand64(), rand64(), rand64(), 1'b0, 0, -1, 1'b1, 1'($urandom), 1'($urandom));
        3: run_instr(IPOPQ, rand64(), rand64(), rand64(), 1'b0, w, int'($urandom_range(0, w)),
                     1'b0, 1'b0, 1'b0);
        default: run_instr(IRMMOVQ, rand64(), rand64(), rand64(), 1'b0, MEM_TMO + 1, -1,
                           1'b0, 1'b0, 1'b0);
      endcase
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
